// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the unified instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } arb_state_t;

    typedef enum logic {
        OWN_IF,
        OWN_DM
    } owner_t;

    localparam int DEFAULT_MEM_LATENCY = 2;
    localparam int DEFAULT_STARVE_MAX  = 2;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_latency_counter.sv
// Loadable down-counter timing the ACCESS phase; tc_o flags the last access cycle.
module arb_latency_counter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MEM_LATENCY = DEFAULT_MEM_LATENCY
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic dec_i,
    output logic tc_o
);

    localparam int                CNT_W    = cnt_width(MEM_LATENCY);
    localparam logic [CNT_W-1:0]  LOAD_VAL = CNT_W'(MEM_LATENCY - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and memory-stage requests onto one single-port memory with a
// fixed-latency access, returning data/completion pulses and per-stage stalls.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int MEM_LATENCY = DEFAULT_MEM_LATENCY,
    parameter int STARVE_MAX  = DEFAULT_STARVE_MAX
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_valid,
    output logic [WIDTH-1:0]      if_rdata,

    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic [ADDR_WIDTH-1:0] dm_addr,
    input  logic [WIDTH-1:0]      dm_wdata,
    output logic                  dm_gnt,
    output logic                  dm_valid,
    output logic [WIDTH-1:0]      dm_rdata,

    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0]      mem_wdata,
    input  logic [WIDTH-1:0]      mem_rdata,

    output logic                  stall_fetch,
    output logic                  stall_mem
);

    localparam int             SW         = cnt_width(STARVE_MAX + 1);
    localparam logic [SW-1:0]  STARVE_SAT = SW'(STARVE_MAX);

    arb_state_t            state_q, state_d;
    owner_t                owner_q, owner_d;
    logic                  we_q, we_d;
    logic                  first_q, first_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0]      wdata_q, wdata_d;
    logic [WIDTH-1:0]      if_rdata_q, if_rdata_d;
    logic [WIDTH-1:0]      dm_rdata_q, dm_rdata_d;
    logic [SW-1:0]         starve_q, starve_d;

    logic grant_if, grant_dm, cnt_load, lat_tc, fetch_first;

    // Fetch overrides the older data request only once it has been passed over STARVE_MAX times.
    assign fetch_first = if_req && (starve_q == STARVE_SAT);

    arb_latency_counter #(
        .MEM_LATENCY (MEM_LATENCY)
    ) u_lat_cnt (
        .clk    (clk),
        .rst    (rst),
        .load_i (cnt_load),
        .dec_i  (state_q == ACCESS),
        .tc_o   (lat_tc)
    );

    // NOTE: every signal written here gets a default first, so no path leaves a latch behind.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        we_d       = we_q;
        first_d    = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        starve_d   = starve_q;
        grant_if   = 1'b0;
        grant_dm   = 1'b0;
        cnt_load   = 1'b0;

        case (state_q)
            IDLE: begin
                if (dm_req && !fetch_first) begin
                    grant_dm = 1'b1;
                    owner_d  = OWN_DM;
                    we_d     = dm_we;
                    addr_d   = dm_addr;
                    wdata_d  = dm_wdata;
                    if (!if_req) begin
                        starve_d = '0;
                    end else if (starve_q != STARVE_SAT) begin
                        starve_d = starve_q + 1'b1;
                    end
                end else if (if_req) begin
                    grant_if = 1'b1;
                    owner_d  = OWN_IF;
                    we_d     = 1'b0;
                    addr_d   = if_addr;
                    wdata_d  = '0;
                    starve_d = '0;
                end
                if (grant_dm || grant_if) begin
                    state_d  = ACCESS;
                    first_d  = 1'b1;
                    cnt_load = 1'b1;
                end
            end
            ACCESS: begin
                if (lat_tc) begin
                    if (!we_q) begin
                        if (owner_q == OWN_DM) dm_rdata_d = mem_rdata;
                        else                   if_rdata_d = mem_rdata;
                    end
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: reset is synchronous and sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= OWN_IF;
            we_q       <= 1'b0;
            first_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            starve_q   <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            first_q    <= first_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
            starve_q   <= starve_d;
        end
    end

    // Strobes are masked by rst so an aborted store never reaches the array.
    assign if_gnt   = grant_if & ~rst;
    assign dm_gnt   = grant_dm & ~rst;
    assign mem_en   = (state_q == ACCESS) & first_q & ~rst;
    assign mem_we   = mem_en & we_q;
    assign if_valid = (state_q == RESP) & (owner_q == OWN_IF) & ~rst;
    assign dm_valid = (state_q == RESP) & (owner_q == OWN_DM) & ~rst;

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;

    assign stall_fetch = if_req & ~if_valid;
    assign stall_mem   = dm_req & ~dm_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: directed table, starvation/reset/latency-1 sequences, random run vs model.
module tb_mem_port_arbiter;

    localparam int          LAT  = 2;
    localparam int          SMAX = 2;
    localparam logic [31:0] JUNK = 32'hBAD0_BAD0;
    localparam logic [7:0]  F_IG = 8'h80, F_DG = 8'h40, F_IV = 8'h20, F_DV = 8'h10;
    localparam logic [7:0]  F_EN = 8'h08, F_WE = 8'h04, F_SF = 8'h02, F_SM = 8'h01;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        if_req, dm_req, dm_we;
    logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic        if_gnt, if_valid, dm_gnt, dm_valid, mem_en, mem_we, stall_fetch, stall_mem;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic [7:0]  flags;

    logic        if_req_1;
    logic [31:0] if_addr_1, mem_rdata_1;
    logic        if_gnt_1, if_valid_1, dm_gnt_1, dm_valid_1, mem_en_1, mem_we_1, stall_fetch_1, stall_mem_1;
    logic [31:0] if_rdata_1, dm_rdata_1, mem_addr_1, mem_wdata_1;

    assign flags = {if_gnt, dm_gnt, if_valid, dm_valid, mem_en, mem_we, stall_fetch, stall_mem};

    mem_port_arbiter #(
        .WIDTH(32), .ADDR_WIDTH(32), .MEM_LATENCY(LAT), .STARVE_MAX(SMAX)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_valid(dm_valid), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall_fetch(stall_fetch), .stall_mem(stall_mem)
    );

    mem_port_arbiter #(
        .WIDTH(32), .ADDR_WIDTH(32), .MEM_LATENCY(1), .STARVE_MAX(SMAX)
    ) dut_l1 (
        .clk(clk), .rst(rst),
        .if_req(if_req_1), .if_addr(if_addr_1), .if_gnt(if_gnt_1), .if_valid(if_valid_1), .if_rdata(if_rdata_1),
        .dm_req(1'b0), .dm_we(1'b0), .dm_addr(32'h0), .dm_wdata(32'h0),
        .dm_gnt(dm_gnt_1), .dm_valid(dm_valid_1), .dm_rdata(dm_rdata_1),
        .mem_en(mem_en_1), .mem_we(mem_we_1), .mem_addr(mem_addr_1), .mem_wdata(mem_wdata_1),
        .mem_rdata(mem_rdata_1), .stall_fetch(stall_fetch_1), .stall_mem(stall_mem_1)
    );

    // Memory contents: a fixed word at 0x10, a hash of the address elsewhere.
    function automatic logic [31:0] word(input logic [31:0] a);
        if (a == 32'h10) return 32'h00A0_0513;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Memory model: read data is only valid MEM_LATENCY-1 cycles after the enable cycle.
    int since_en;
    always @(posedge clk) begin
        if (rst)                               since_en <= 0;
        else if (mem_en)                       since_en <= 1;
        else if (since_en != 0 && since_en < LAT) since_en <= since_en + 1;
        else                                   since_en <= 0;
    end
    always_comb mem_rdata   = (since_en == LAT - 1) ? word(mem_addr) : JUNK;
    always_comb mem_rdata_1 = mem_en_1 ? word(mem_addr_1) : JUNK;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        dm_req;
        logic        dm_we;
        logic [31:0] dm_addr;
        logic [31:0] dm_wdata;
        logic [7:0]  exp_flags;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    function automatic vec_t mk(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                                input logic [31:0] da, input logic [31:0] dd, input logic [7:0] fl,
                                input logic [31:0] ea, input logic [31:0] ew, input logic [31:0] er);
        vec_t v;
        v.if_req = ir; v.if_addr = ia; v.dm_req = dr; v.dm_we = dw; v.dm_addr = da; v.dm_wdata = dd;
        v.exp_flags = fl; v.exp_addr = ea; v.exp_wdata = ew; v.exp_rdata = er;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        if_req = v.if_req; if_addr = v.if_addr;
        dm_req = v.dm_req; dm_we = v.dm_we; dm_addr = v.dm_addr; dm_wdata = v.dm_wdata;
    endtask

    task automatic idle_inputs();
        if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    endtask

    vec_t tbl[18];

    // Reference model state for the random run: phase = cycles since the grant (0 = port free).
    int          m_phase;
    int          m_starve;
    logic        m_dm, m_we;
    logic [31:0] m_addr, m_wdata, m_if_rdata, m_dm_rdata;
    logic        if_pend, dm_pend;
    logic        e_ig, e_dg, e_iv, e_dv, e_en, e_we;

    task automatic model_cycle(input int cyc);
        e_ig = 1'b0;
        e_dg = 1'b0;
        if (m_phase == 0) begin
            if (dm_req && !(if_req && m_starve == SMAX)) e_dg = 1'b1;
            else if (if_req)                              e_ig = 1'b1;
        end
        e_en = (m_phase == 1);
        e_we = e_en && m_we;
        e_iv = (m_phase == LAT + 1) && !m_dm;
        e_dv = (m_phase == LAT + 1) && m_dm;
        check($sformatf("rnd[%0d].flags", cyc), flags,
              {e_ig, e_dg, e_iv, e_dv, e_en, e_we, if_req && !e_iv, dm_req && !e_dv});
        if (e_en) check($sformatf("rnd[%0d].mem_addr", cyc), mem_addr, m_addr);
        if (e_we) check($sformatf("rnd[%0d].mem_wdata", cyc), mem_wdata, m_wdata);
        if (e_iv) check($sformatf("rnd[%0d].if_rdata", cyc), if_rdata, m_if_rdata);
        if (e_dv) check($sformatf("rnd[%0d].dm_rdata", cyc), dm_rdata, m_dm_rdata);

        if (m_phase == 0) begin
            if (e_dg) begin
                m_dm = 1'b1; m_we = dm_we; m_addr = dm_addr; m_wdata = dm_wdata;
                m_starve = if_req ? ((m_starve < SMAX) ? m_starve + 1 : SMAX) : 0;
                m_phase = 1;
            end else if (e_ig) begin
                m_dm = 1'b0; m_we = 1'b0; m_addr = if_addr; m_wdata = '0;
                m_starve = 0;
                m_phase = 1;
            end
        end else if (m_phase <= LAT) begin
            if (m_phase == LAT && !m_we) begin
                if (m_dm) m_dm_rdata = word(m_addr);
                else      m_if_rdata = word(m_addr);
            end
            m_phase++;
        end else begin
            m_phase = 0;
        end
        if (e_ig) if_pend = 1'b0;
        if (e_dg) dm_pend = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       gnt_seq [6];
        logic       exp_seq [6];
        int         ng;
        int         k;

        // Fetch-only, fetch-vs-load contention, then a store that must leave dm_rdata alone.
        tbl[0]  = mk(1, 32'h10, 0, 0, 0, 0,                  F_IG | F_SF,        0, 0, 0);
        tbl[1]  = mk(1, 32'h10, 0, 0, 0, 0,                  F_EN | F_SF,        32'h10, 0, 0);
        tbl[2]  = mk(1, 32'h10, 0, 0, 0, 0,                  F_SF,               0, 0, 0);
        tbl[3]  = mk(1, 32'h10, 0, 0, 0, 0,                  F_IV,               0, 0, 32'h00A0_0513);
        tbl[4]  = mk(0, 0,      0, 0, 0, 0,                  8'h00,              0, 0, 0);
        tbl[5]  = mk(1, 32'h20, 1, 0, 32'h100, 0,            F_DG | F_SF | F_SM, 0, 0, 0);
        tbl[6]  = mk(1, 32'h20, 1, 0, 32'h100, 0,            F_EN | F_SF | F_SM, 32'h100, 0, 0);
        tbl[7]  = mk(1, 32'h20, 1, 0, 32'h100, 0,            F_SF | F_SM,        0, 0, 0);
        tbl[8]  = mk(1, 32'h20, 1, 0, 32'h100, 0,            F_DV | F_SF,        0, 0, word(32'h100));
        tbl[9]  = mk(1, 32'h20, 0, 0, 0, 0,                  F_IG | F_SF,        0, 0, 0);
        tbl[10] = mk(1, 32'h20, 0, 0, 0, 0,                  F_EN | F_SF,        32'h20, 0, 0);
        tbl[11] = mk(1, 32'h20, 0, 0, 0, 0,                  F_SF,               0, 0, 0);
        tbl[12] = mk(1, 32'h20, 0, 0, 0, 0,                  F_IV,               0, 0, word(32'h20));
        tbl[13] = mk(0, 0,      1, 1, 32'h200, 32'hDEADBEEF, F_DG | F_SM,        0, 0, 0);
        tbl[14] = mk(0, 0,      1, 1, 32'h200, 32'hDEADBEEF, F_EN | F_WE | F_SM, 32'h200, 32'hDEADBEEF, 0);
        tbl[15] = mk(0, 0,      1, 1, 32'h200, 32'hDEADBEEF, F_SM,               0, 0, 0);
        tbl[16] = mk(0, 0,      1, 1, 32'h200, 32'hDEADBEEF, F_DV,               0, 0, word(32'h100));
        tbl[17] = mk(0, 0,      0, 0, 0, 0,                  8'h00,              0, 0, 0);

        exp_seq = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        if_req_1 = 1'b0;
        if_addr_1 = '0;
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset.flags", flags, 8'h00);
        check("reset.mem_addr", mem_addr, 32'h0);
        check("reset.mem_wdata", mem_wdata, 32'h0);
        check("reset.if_rdata", if_rdata, 32'h0);
        check("reset.dm_rdata", dm_rdata, 32'h0);

        for (int i = 0; i < 18; i++) begin
            @(posedge clk);
            #1 drive(tbl[i]);
            @(negedge clk);
            check($sformatf("tbl[%0d].flags", i), flags, tbl[i].exp_flags);
            if ((tbl[i].exp_flags & F_EN) != 0) check($sformatf("tbl[%0d].mem_addr", i), mem_addr, tbl[i].exp_addr);
            if ((tbl[i].exp_flags & F_WE) != 0) check($sformatf("tbl[%0d].mem_wdata", i), mem_wdata, tbl[i].exp_wdata);
            if ((tbl[i].exp_flags & F_IV) != 0) check($sformatf("tbl[%0d].if_rdata", i), if_rdata, tbl[i].exp_rdata);
            if ((tbl[i].exp_flags & F_DV) != 0) check($sformatf("tbl[%0d].dm_rdata", i), dm_rdata, tbl[i].exp_rdata);
        end

        // Starvation: both requesters held high, fetch must break through every third grant.
        ng = 0;
        for (int c = 0; c < 60 && ng < 6; c++) begin
            @(posedge clk);
            #1;
            if_req = 1'b1; if_addr = 32'h300;
            dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h304;
            @(negedge clk);
            check($sformatf("starve[%0d].onehot", c), {31'b0, if_gnt & dm_gnt}, 32'h0);
            if (if_gnt || dm_gnt) begin
                gnt_seq[ng] = if_gnt;
                ng++;
            end
        end
        check("starve.grant_count", ng, 6);
        for (int g = 0; g < 6; g++) check($sformatf("starve.grant%0d_is_fetch", g), {31'b0, gnt_seq[g]}, {31'b0, exp_seq[g]});
        @(posedge clk);
        #1 idle_inputs();
        repeat (5) @(posedge clk);

        // Reset during the first ACCESS cycle of a store.
        #1;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h500; dm_wdata = 32'h1234_5678;
        @(negedge clk);
        check("rstmid.dm_gnt", {31'b0, dm_gnt}, 32'h1);
        @(posedge clk);
        #1 rst = 1'b1; dm_req = 1'b0;
        @(negedge clk);
        check("rstmid.flags_in_reset", flags, 8'h00);
        @(posedge clk);
        #1 rst = 1'b0; if_req = 1'b1; if_addr = 32'h40;
        @(negedge clk);
        check("rstmid.flags_after", flags, F_IG | F_SF);
        check("rstmid.mem_addr", mem_addr, 32'h0);
        check("rstmid.mem_wdata", mem_wdata, 32'h0);
        check("rstmid.if_rdata", if_rdata, 32'h0);
        check("rstmid.dm_rdata", dm_rdata, 32'h0);
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("rstmid.fetch%0d.flags", c), flags,
                  (c == 1) ? (F_EN | F_SF) : ((c == 2) ? F_SF : F_IV));
        end
        check("rstmid.if_rdata_fetch", if_rdata, word(32'h40));
        @(posedge clk);
        #1 idle_inputs();

        // MEM_LATENCY = 1: back-to-back fetches on the second instance.
        k = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1 if_req_1 = 1'b1; if_addr_1 = 32'h400 + 32'(4 * k);
            @(negedge clk);
            check($sformatf("lat1[%0d].gnt_en_valid", c), {29'b0, if_gnt_1, mem_en_1, if_valid_1},
                  {29'b0, c % 3 == 0, c % 3 == 1, c % 3 == 2});
            if (c % 3 == 2) check($sformatf("lat1[%0d].if_rdata", c), if_rdata_1, word(32'h400 + 32'(4 * (c / 3))));
            if (if_gnt_1) k++;
        end
        @(posedge clk);
        #1 if_req_1 = 1'b0;

        // Random traffic against the reference model.
        m_phase = 0; m_starve = 0; m_dm = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
        m_if_rdata = word(32'h40); m_dm_rdata = 32'h0;
        if_pend = 1'b0; dm_pend = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk);
            #1;
            if (!if_pend && $urandom_range(0, 99) < 60) begin
                if_pend = 1'b1;
                if_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!dm_pend && $urandom_range(0, 99) < 50) begin
                dm_pend  = 1'b1;
                dm_we    = 1'($urandom_range(0, 1));
                dm_addr  = $urandom & 32'hFFFF_FFFC;
                dm_wdata = $urandom;
            end
            if_req = if_pend;
            dm_req = dm_pend;
            @(negedge clk);
            model_cycle(c);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified instruction/data memory between two requesters: the fetch stage (instruction reads) and the memory stage (loads and stores).
- Sequences each memory transaction through a fixed-latency access.
- Returns read data and a completion pulse to the requester, and drives per-requester stall outputs into the hazard logic.
- Sits between the fetch and memory pipeline stages and the memory array.

Parameters:
- WIDTH, 32, data word width.
- ADDR_WIDTH, 32, byte-address width.
- MEM_LATENCY, 2, cycles from the memory enable cycle to valid mem_rdata. Must be >= 1.
- STARVE_MAX, 2, maximum consecutive data grants allowed while a fetch request is pending.

Ports:
- clk  in  1  CPU clock
- rst  in  1  reset
- if_req  in  1  fetch requests an instruction read
- if_addr  in  ADDR_WIDTH  fetch address
- if_gnt  out  1  fetch request accepted this cycle
- if_valid  out  1  one-cycle pulse: if_rdata valid
- if_rdata  out  WIDTH  instruction word
- dm_req  in  1  memory stage requests an access
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_WIDTH  data address
- dm_wdata  in  WIDTH  store data
- dm_gnt  out  1  data request accepted this cycle
- dm_valid  out  1  one-cycle pulse: load data valid, or store complete
- dm_rdata  out  WIDTH  load data
- mem_en  out  1  memory access enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  WIDTH  memory write data
- mem_rdata  in  WIDTH  memory read data
- stall_fetch  out  1  hold the fetch stage
- stall_mem  out  1  hold the memory stage

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - state = IDLE.
  - All gnt, valid and mem_en/mem_we outputs = 0.
  - if_rdata, dm_rdata, mem_addr and mem_wdata registers = 0.
  - Starvation counter = 0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Grant decision is combinational in the same cycle; the granted gnt is high for exactly that cycle.
  - dm_req wins over if_req, because the memory stage holds the older instruction.
  - Exception: if the starvation counter == STARVE_MAX and if_req=1, fetch wins.
  - On a grant, register the granted address, the we bit (0 for fetch) and the wdata; record the owner; go to ACCESS.
  - No request: stay in IDLE.
- ACCESS:
  - Lasts exactly MEM_LATENCY cycles, timed by a down-counter.
  - mem_en=1, and mem_we=latched we, only in the first ACCESS cycle.
  - mem_addr and mem_wdata hold the latched values for the whole ACCESS period.
  - On the last ACCESS cycle, capture mem_rdata into the owner's rdata register (loads and fetches only), then go to RESP.
- RESP:
  - The owner's valid = 1 for one cycle. Go to IDLE.
  - No grant is issued in RESP.
- Timing for a request in IDLE at cycle t:
  - gnt at t.
  - mem_en at t+1.
  - valid at t+MEM_LATENCY+1.
  - Earliest next grant at t+MEM_LATENCY+2.
- Store: dm_valid pulses in RESP as a completion ack; dm_rdata keeps its previous value.
- rdata registers hold their value until the next completed read by the same owner.
- Starvation counter:
  - Increments on a data grant while if_req=1, saturating at STARVE_MAX.
  - Clears on any fetch grant.
  - Clears on a data grant while if_req=0.
- Requester rules:
  - A requester holds req and its fields stable until its gnt.
  - Changes after gnt are ignored.
  - Dropping req after gnt does not abort the transaction; it completes and valid still pulses.
- Stall outputs (combinational):
  - stall_fetch = if_req & ~if_valid.
  - stall_mem = dm_req & ~dm_valid.
- Simultaneous requests in IDLE: exactly one gnt is asserted; the loser stays stalled and is re-evaluated on the next IDLE cycle.
- Reset mid-transaction:
  - Abort, go to IDLE next cycle.
  - No valid is emitted.
  - mem_en=0 from the reset cycle onward, so no partial write is issued after reset.

Decomposition:
- Shared package: enum arb_state_t {IDLE, ACCESS, RESP}; enum owner_t {OWN_IF, OWN_DM}; default-latency constant.
- One natural sub-module: arb_latency_counter. It is a loadable down-counter with a terminal-count flag and sizes itself from MEM_LATENCY.
- Grant logic and the FSM stay in mem_port_arbiter.

Test Plan:
1. Fetch only, MEM_LATENCY=2:
   - Stimulus: if_req=1, if_addr=0x0000_0010 at cycle 0; memory returns 0x00A00513.
   - Required: if_gnt at 0, mem_en=1/mem_we=0/mem_addr=0x10 at 1, if_valid=1 with if_rdata=0x00A00513 at 3, stall_fetch=1 for cycles 0-2.
2. Simultaneous if_req and dm_req (load from 0x100) at cycle 0:
   - Required: dm_gnt at 0, dm_valid at 3; if_gnt at 4, if_valid at 7; if_gnt never at 0.
3. Store:
   - Stimulus: dm_we=1, dm_addr=0x200, dm_wdata=0xDEADBEEF.
   - Required: a single mem_en/mem_we cycle carrying addr 0x200 and data 0xDEADBEEF; dm_valid pulse; dm_rdata unchanged from its prior value.
4. Starvation, STARVE_MAX=2:
   - Stimulus: if_req and dm_req held high continuously.
   - Required: grant sequence DM, DM, IF, DM, DM, IF.
5. Reset mid-transaction:
   - Stimulus: rst=1 during the first ACCESS cycle of a store.
   - Required: no valid pulse; state back in IDLE; all outputs at reset values; a new if_req is granted on the first cycle after rst falls.
6. MEM_LATENCY=1:
   - Stimulus: back-to-back fetches.
   - Required: gnt every 3 cycles, valid 2 cycles after each gnt.
